buzzer_ctrl: RTL
================

Name: buzzer_ctrl

Overview:
Tone-pattern sequencer and arbiter that drives the existing square-wave buzzer generator through its pwm_freq/enable inputs. It serves three requesters: keypad click, error double-beep and RTC alarm. Each request is turned into a timed on/off pattern with fixed priority: alarm > error > key. It sits between the keypad/DS1302 control logic and the buzzer generator.

Parameters:
sys_clk_freq, 100_000_000, system clock in Hz; 1 ms tick = sys_clk_freq/1000 cycles
KEY_FREQ, 2000, key-click tone in Hz (1..8191)
KEY_MS, 50, key-click on time in ms (>=1)
ERR_FREQ, 500, error tone in Hz (1..8191)
ERR_ON_MS, 100, on time of each error beep in ms (>=1)
ERR_OFF_MS, 100, gap between the two error beeps in ms (>=1)
ALM_FREQ, 4000, alarm tone in Hz (1..8191)
ALM_ON_MS, 200, alarm beep on time in ms (>=1)
ALM_OFF_MS, 300, alarm gap in ms (>=1)

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous reset, active-high
key_req  input  1  single-cycle pulse requesting a key click
err_req  input  1  single-cycle pulse requesting an error double-beep
alarm_on  input  1  level; alarm pattern repeats while high
pwm_freq  output  13  tone frequency to the buzzer generator, Hz
buzzer_en  output  1  enable to the buzzer generator
active_src  output  2  00 idle, 01 key, 10 error, 11 alarm
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_p=1): state IDLE; key_pend and err_pend = 0; ms prescaler and phase counter = 0; buzzer_en=0; pwm_freq=KEY_FREQ (never 0, so the downstream divider is never divided by zero); active_src=00; busy=0.
- All outputs are registered. A request sampled at cycle n gives the new state and outputs at cycle n+1.
- Timebase: the prescaler counts 0..sys_clk_freq/1000-1 and pulses ms_tick at terminal count. Prescaler and phase counter clear on every state entry, so a phase of N ms lasts exactly N*(sys_clk_freq/1000) cycles.
- States: IDLE, KEY_ON, ERR_ON1, ERR_GAP, ERR_ON2, ALM_ON, ALM_GAP.
- buzzer_en=1 only in KEY_ON, ERR_ON1, ERR_ON2 and ALM_ON.
- pwm_freq loads the state's tone on entry to an ON state and holds its value otherwise.
- active_src follows the state group.
- Transitions, in priority order, evaluated every cycle:
  1. alarm_on=1 and state not ALM_ON/ALM_GAP -> ALM_ON from any state. This preempts key or error at once; the preempted pattern is dropped and its pend bit cleared.
  2. alarm_on=0 while in ALM_ON/ALM_GAP -> IDLE immediately (buzzer_en=0 next cycle). The current beep is not completed.
  3. ALM_ON -> ALM_GAP after ALM_ON_MS; ALM_GAP -> ALM_ON after ALM_OFF_MS.
  4. (err_req or err_pend) in IDLE or KEY_ON -> ERR_ON1. An error preempts a key click in progress, and that click is dropped.
  5. ERR_ON1 -> ERR_GAP after ERR_ON_MS; ERR_GAP -> ERR_ON2 after ERR_OFF_MS; ERR_ON2 -> IDLE after ERR_ON_MS.
  6. (key_req or key_pend) in IDLE -> KEY_ON; KEY_ON -> IDLE after KEY_MS.
- Pending rules:
  - key_req during ERR_* sets key_pend; the click plays after the error completes (IDLE for 1 cycle, then KEY_ON).
  - key_req during KEY_ON is ignored (no retrigger).
  - err_req during ERR_* is ignored.
  - key_req and err_req during an alarm are discarded.
  - A pend bit clears on entry to its own pattern.
- Simultaneous events:
  - key_req and err_req together in IDLE -> ERR_ON1, and key_pend is set.
  - alarm_on rising together with any request -> ALM_ON, and the request is discarded.
  - A request on the same cycle a pattern ends is taken, per the rules above, on the following cycle.
- Reset mid-pattern: immediate return to reset values; all pending requests are lost.

Test Plan:
1. sys_clk_freq=100_000 (tick = 100 cycles). key_req pulse at cycle 10 -> buzzer_en=1, pwm_freq=2000, active_src=01 from cycle 11 for exactly 5000 cycles, then 0 and busy=0.
2. err_req pulse -> two 10000-cycle beeps at pwm_freq=500 separated by a 10000-cycle gap with buzzer_en=0; total busy time 30000 cycles.
3. key_req 500 cycles after err_req -> the double-beep completes untouched, 1 idle cycle, then a 5000-cycle beep at 2000 Hz.
4. alarm_on raised 2000 cycles into ERR_ON1 -> next cycle pwm_freq=4000, active_src=11, pattern 20000 on / 30000 off repeated 3 times. Lowering alarm_on mid-beep drops buzzer_en the next cycle, and no error beep resumes.
5. key_req and err_req on the same cycle from IDLE -> error double-beep first, then the key click. key_req pulses at cycles 100 and 1000 of one click -> only a single 5000-cycle click.
6. reset_p asserted asynchronously mid-ALM_ON -> buzzer_en=0, pwm_freq=2000, busy=0 immediately. After release with alarm_on still 1 -> ALM_ON begins one cycle after the first clock edge.

Source files
------------

// File: rtl/buzzer_if.sv
// Request/tone bus between the keypad/RTC control logic and the buzzer sequencer.
// The master raises requests; the slave (buzzer_ctrl) drives the tone outputs.
interface buzzer_if;
  logic        key_req;
  logic        err_req;
  logic        alarm_on;
  logic [12:0] pwm_freq;
  logic        buzzer_en;
  logic [1:0]  active_src;
  logic        busy;

  modport master (
    output key_req, err_req, alarm_on,
    input  pwm_freq, buzzer_en, active_src, busy
  );

  modport slave (
    input  key_req, err_req, alarm_on,
    output pwm_freq, buzzer_en, active_src, busy
  );
endinterface

// File: rtl/buzzer_ctrl.sv
// Tone-pattern sequencer: turns key/error/alarm requests into timed on/off beeps
// with fixed priority alarm > error > key, feeding the square-wave buzzer generator.
module buzzer_ctrl #(
  parameter int unsigned sys_clk_freq = 100_000_000,
  parameter int unsigned KEY_FREQ     = 2000,
  parameter int unsigned KEY_MS       = 50,
  parameter int unsigned ERR_FREQ     = 500,
  parameter int unsigned ERR_ON_MS    = 100,
  parameter int unsigned ERR_OFF_MS   = 100,
  parameter int unsigned ALM_FREQ     = 4000,
  parameter int unsigned ALM_ON_MS    = 200,
  parameter int unsigned ALM_OFF_MS   = 300
) (
  input  logic   clk,
  input  logic   reset_p,
  buzzer_if.slave bus
);

  localparam int unsigned TICK = sys_clk_freq / 1000;
  localparam int unsigned PW   = (TICK > 1) ? $clog2(TICK) : 1;

  typedef enum logic [2:0] {
    IDLE, KEY_ON, ERR_ON1, ERR_GAP, ERR_ON2, ALM_ON, ALM_GAP
  } state_t;

  state_t        state, state_n;
  logic          key_pend, key_pend_n;
  logic [PW-1:0] presc;
  logic [31:0]   phase;
  logic          ms_tick, done, entry;
  logic          in_alm, in_err;

  logic [12:0]   pwm_freq_q, pwm_freq_n;
  logic          buzzer_en_q;
  logic [1:0]    active_src_q;
  logic          busy_q;

  function automatic logic is_on(input state_t s);
    return (s == KEY_ON) || (s == ERR_ON1) || (s == ERR_ON2) || (s == ALM_ON);
  endfunction

  function automatic logic [1:0] src_of(input state_t s);
    case (s)
      KEY_ON:                   return 2'b01;
      ERR_ON1, ERR_GAP, ERR_ON2: return 2'b10;
      ALM_ON, ALM_GAP:          return 2'b11;
      default:                  return 2'b00;
    endcase
  endfunction

  function automatic logic [12:0] tone_of(input state_t s);
    case (s)
      ERR_ON1, ERR_ON2: return 13'(ERR_FREQ);
      ALM_ON:           return 13'(ALM_FREQ);
      default:          return 13'(KEY_FREQ);
    endcase
  endfunction

  function automatic logic [31:0] dur_of(input state_t s);
    case (s)
      KEY_ON:           return 32'(KEY_MS);
      ERR_ON1, ERR_ON2: return 32'(ERR_ON_MS);
      ERR_GAP:          return 32'(ERR_OFF_MS);
      ALM_ON:           return 32'(ALM_ON_MS);
      ALM_GAP:          return 32'(ALM_OFF_MS);
      default:          return 32'd1;
    endcase
  endfunction

  assign ms_tick = (presc == PW'(TICK - 1));
  assign done    = ms_tick && (phase == dur_of(state) - 32'd1);
  assign in_alm  = (state == ALM_ON) || (state == ALM_GAP);
  assign in_err  = (state == ERR_ON1) || (state == ERR_GAP) || (state == ERR_ON2);
  assign entry   = (state_n != state);

  always_comb begin
    state_n    = state;
    key_pend_n = key_pend;
    if (bus.alarm_on && !in_alm) begin
      // Alarm takes over from anything; whatever was playing or queued is dropped.
      state_n    = ALM_ON;
      key_pend_n = 1'b0;
    end else if (in_alm) begin
      if (!bus.alarm_on)                  state_n = IDLE;
      else if (done && state == ALM_ON)   state_n = ALM_GAP;
      else if (done)                      state_n = ALM_ON;
    end else if (bus.err_req && (state == IDLE || state == KEY_ON)) begin
      state_n = ERR_ON1;
      if (state == IDLE && bus.key_req) key_pend_n = 1'b1;
    end else if (in_err) begin
      if (bus.key_req) key_pend_n = 1'b1;
      if (done) begin
        case (state)
          ERR_ON1: state_n = ERR_GAP;
          ERR_GAP: state_n = ERR_ON2;
          default: state_n = IDLE;
        endcase
      end
    end else if (state == IDLE) begin
      if (bus.key_req || key_pend) begin
        state_n    = KEY_ON;
        key_pend_n = 1'b0;
      end
    end else if (done) begin
      state_n = IDLE;
    end

    pwm_freq_n = pwm_freq_q;
    if (entry && is_on(state_n)) pwm_freq_n = tone_of(state_n);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state        <= IDLE;
      key_pend     <= 1'b0;
      presc        <= '0;
      phase        <= '0;
      pwm_freq_q   <= 13'(KEY_FREQ);
      buzzer_en_q  <= 1'b0;
      active_src_q <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_n;
      key_pend     <= key_pend_n;
      presc        <= (entry || ms_tick) ? '0 : presc + PW'(1);
      phase        <= entry ? '0 : (ms_tick ? phase + 32'd1 : phase);
      pwm_freq_q   <= pwm_freq_n;
      buzzer_en_q  <= is_on(state_n);
      active_src_q <= src_of(state_n);
      busy_q       <= (state_n != IDLE);
    end
  end

  assign bus.pwm_freq   = pwm_freq_q;
  assign bus.buzzer_en  = buzzer_en_q;
  assign bus.active_src = active_src_q;
  assign bus.busy       = busy_q;

endmodule
